spfp_norm_round: RTL and testbench

SPFP_NORM_ROUND -- requirements
Module: spfp_norm_round

---
 rtl/spfp_pkg.sv | 27 ++
 rtl/spfp_lzc.sv | 26 ++
 rtl/spfp_norm_round.sv | 142 ++++++++++++++
 tb/tb_spfp_norm_round.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/spfp_pkg.sv
// ============================================================
// spfp_pkg : shared constants and stage record for spfp_norm_round
// Rev 1.0
// ============================================================
`default_nettype none

package spfp_pkg;

  localparam int          BIAS        = 127;
  localparam int          EXP_MAX     = 255;
  localparam logic [31:0] QNAN        = 32'h7FC0_0000;
  localparam int          RAW_MANT_W  = 28;
  localparam int          NORM_MANT_W = RAW_MANT_W - 1;

  // Normalized record between the two stages: hidden bit at [26], G/R/S at [2:0]
  typedef struct packed {
    logic                   sign;
    logic                   nan;
    logic                   inf;
    logic                   zero;
    logic signed [9:0]      exp;
    logic [NORM_MANT_W-1:0] mant;
  } stage_t;

endpackage

`default_nettype wire

// File: rtl/spfp_lzc.sv
// ============================================================
// spfp_lzc : combinational leading-zero count of a 27-bit mantissa
// Rev 1.0
// ============================================================
`default_nettype none

module spfp_lzc
  import spfp_pkg::*;
(
  input  logic [NORM_MANT_W-1:0] data_i,
  output logic [4:0]             count_o
);

  // Ascending scan so the most significant set bit wins; all-zero input yields 27
  always_comb begin
    count_o = 5'd27;
    for (int i = 0; i < NORM_MANT_W; i++) begin
      if (data_i[i]) begin
        count_o = 5'(NORM_MANT_W - 1 - i);
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/spfp_norm_round.sv
// ============================================================
// spfp_norm_round : 2-stage normalize + round-to-nearest-even to IEEE single
// Rev 1.0
// ============================================================
`default_nettype none

module spfp_norm_round
  import spfp_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  in_sign,
  input  logic [7:0]            in_exp,
  input  logic [RAW_MANT_W-1:0] in_mant,
  input  logic                  in_nan,
  input  logic                  in_inf,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [31:0]           z,
  output logic                  out_overflow,
  output logic                  out_underflow
);

  localparam logic signed [9:0] EXP_OVF = EXP_MAX[9:0];

  logic        s1_valid_q, s1_valid_d;
  stage_t      s1_q, s1_d, norm;
  logic        out_valid_q, out_valid_d;
  logic [31:0] z_q, z_d;
  logic        ovf_q, ovf_d, unf_q, unf_d;

  logic        s2_advance;
  logic        accept;
  logic [4:0]  lzc;

  logic signed [9:0] exp_s1, exp_rnd;
  logic [24:0]       sig_rnd;
  logic              rnd_inc;
  logic [22:0]       frac_rnd;
  logic [31:0]       res_z;
  logic              res_ovf, res_unf;

  spfp_lzc u_lzc (
    .data_i  (in_mant[NORM_MANT_W-1:0]),
    .count_o (lzc)
  );

  assign s2_advance = !out_valid_q || out_ready;
  assign in_ready   = !rst && (!s1_valid_q || s2_advance);
  assign accept     = in_valid && in_ready;

  // Stage 1: normalize so the hidden bit lands at [26]
  always_comb begin
    norm.sign = in_sign;
    norm.nan  = in_nan;
    norm.inf  = in_inf;
    norm.zero = (in_mant == '0);
    if (in_mant[RAW_MANT_W-1]) begin
      norm.mant = {in_mant[27:2], in_mant[1] | in_mant[0]};
      norm.exp  = {2'b00, in_exp} + 10'd1;
    end else begin
      norm.mant = in_mant[NORM_MANT_W-1:0] << lzc;
      norm.exp  = {2'b00, in_exp} - {5'd0, lzc};
    end
  end

  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_d       = s1_q;
    if (in_ready) begin
      s1_valid_d = in_valid;
    end
    if (accept) begin
      s1_d = norm;
    end
  end

  // Stage 2: round to nearest even, then classify the final exponent
  always_comb begin
    exp_s1   = s1_q.exp;
    rnd_inc  = s1_q.mant[2] & (s1_q.mant[1] | s1_q.mant[0] | s1_q.mant[3]);
    sig_rnd  = {1'b0, s1_q.mant[26:3]} + {24'd0, rnd_inc};
    exp_rnd  = exp_s1 + $signed({9'd0, sig_rnd[24]});
    frac_rnd = sig_rnd[24] ? sig_rnd[23:1] : sig_rnd[22:0];
    res_z    = '0;
    res_ovf  = 1'b0;
    res_unf  = 1'b0;
    if (s1_q.nan) begin
      res_z = QNAN;
    end else if (s1_q.inf) begin
      res_z = {s1_q.sign, 8'hFF, 23'h0};
    end else if (s1_q.zero) begin
      res_z = '0;
    end else if (exp_rnd >= EXP_OVF) begin
      res_z   = {s1_q.sign, 8'hFF, 23'h0};
      res_ovf = 1'b1;
    end else if (exp_rnd <= 10'sd0) begin
      res_z   = {s1_q.sign, 31'h0};
      res_unf = 1'b1;
    end else begin
      res_z = {s1_q.sign, exp_rnd[7:0], frac_rnd};
    end
  end

  always_comb begin
    out_valid_d = out_valid_q;
    z_d         = z_q;
    ovf_d       = ovf_q;
    unf_d       = unf_q;
    if (s2_advance) begin
      out_valid_d = s1_valid_q;
      z_d         = res_z;
      ovf_d       = res_ovf;
      unf_d       = res_unf;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q  <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      out_valid_q <= out_valid_d;
    end
    s1_q  <= s1_d;
    z_q   <= z_d;
    ovf_q <= ovf_d;
    unf_q <= unf_d;
  end

  // Datapath flops are never reset, so outputs are masked whenever no result is live
  assign out_valid     = out_valid_q && !rst;
  assign z             = out_valid ? z_q : '0;
  assign out_overflow  = out_valid && ovf_q;
  assign out_underflow = out_valid && unf_q;

endmodule

`default_nettype wire

// File: tb/tb_spfp_norm_round.sv
// ============================================================
// tb_spfp_norm_round : directed self-checking bench for spfp_norm_round
// Rev 1.0
// ============================================================
`default_nettype none

module tb_spfp_norm_round;
  import spfp_pkg::*;

  typedef struct {
    logic        s;
    logic [7:0]  e;
    logic [27:0] m;
    logic        n;
    logic        i;
    logic [31:0] z;
    logic        ov;
    logic        un;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_sign, in_nan, in_inf, out_ready;
  logic [7:0]  in_exp;
  logic [27:0] in_mant;
  logic        in_ready, out_valid, out_overflow, out_underflow;
  logic [31:0] z;

  int checks = 0;
  int errors = 0;

  spfp_norm_round dut (
    .clk           (clk),
    .rst           (rst),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_sign       (in_sign),
    .in_exp        (in_exp),
    .in_mant       (in_mant),
    .in_nan        (in_nan),
    .in_inf        (in_inf),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .z             (z),
    .out_overflow  (out_overflow),
    .out_underflow (out_underflow)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic load(input vec_t v);
    in_sign = v.s;
    in_exp  = v.e;
    in_mant = v.m;
    in_nan  = v.n;
    in_inf  = v.i;
  endtask

  // Entered at posedge+1 with an idle pipeline and out_ready=1
  task automatic send_and_get(input vec_t v, output logic [31:0] zz, output logic ov,
                              output logic un, output int lat, output bit got);
    load(v);
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    got = 1'b0;
    lat = 0;
    zz  = '0;
    ov  = 1'b0;
    un  = 1'b0;
    for (int k = 1; k <= 10 && !got; k++) begin
      if (out_valid) begin
        got = 1'b1;
        lat = k;
        zz  = z;
        ov  = out_overflow;
        un  = out_underflow;
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    in_sign = 1'b0; in_exp = '0; in_mant = '0; in_nan = 1'b0; in_inf = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready: got %b want 0", in_ready); end
    checks++; if (z !== 32'h0) begin errors++; $display("FAIL reset_z: got %h want 00000000", z); end
    checks++; if ({out_overflow, out_underflow} !== 2'b00) begin errors++; $display("FAIL reset_flags: got %b want 00", {out_overflow, out_underflow}); end
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL release_in_ready: got %b want 1", in_ready); end
    @(posedge clk); #1;
  endtask

  task automatic test_latency;
    vec_t v;
    logic [31:0] zz; logic ov, un; int lat; bit got;
    v = '{1'b0, 8'(BIAS), 28'h8000000, 1'b0, 1'b0, 32'h40000000, 1'b0, 1'b0};
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL lat_in_ready: got %b want 1", in_ready); end
    send_and_get(v, zz, ov, un, lat, got);
    checks++; if (!got) begin errors++; $display("FAIL lat_timeout: got no output want one"); end
    checks++; if (lat !== 2) begin errors++; $display("FAIL lat_cycles: got %0d want 2", lat); end
    checks++; if ({zz, ov, un} !== {v.z, v.ov, v.un}) begin errors++; $display("FAIL lat_value: got %h/%b%b want %h/%b%b", zz, ov, un, v.z, v.ov, v.un); end
  endtask

  task automatic test_zero_underflow;
    vec_t tbl[5];
    logic [31:0] zz; logic ov, un; int lat; bit got;
    tbl[0] = '{1'b1, 8'd100, 28'h0000000, 1'b0, 1'b0, 32'h00000000, 1'b0, 1'b0};
    tbl[1] = '{1'b0, 8'd1,   28'h0200000, 1'b0, 1'b0, 32'h00000000, 1'b0, 1'b1};
    tbl[2] = '{1'b1, 8'd1,   28'h0200000, 1'b0, 1'b0, 32'h80000000, 1'b0, 1'b1};
    tbl[3] = '{1'b0, 8'd1,   28'h4000000, 1'b0, 1'b0, 32'h00800000, 1'b0, 1'b0};
    tbl[4] = '{1'b0, 8'd0,   28'h4000000, 1'b0, 1'b0, 32'h00000000, 1'b0, 1'b1};
    for (int t = 0; t < 5; t++) begin
      send_and_get(tbl[t], zz, ov, un, lat, got);
      checks++;
      if (!got || {zz, ov, un} !== {tbl[t].z, tbl[t].ov, tbl[t].un}) begin
        errors++;
        $display("FAIL zero_unf[%0d]: got %h/%b%b (valid %b) want %h/%b%b", t, zz, ov, un, got, tbl[t].z, tbl[t].ov, tbl[t].un);
      end
    end
  endtask

  task automatic test_rounding;
    vec_t tbl[6];
    logic [31:0] zz; logic ov, un; int lat; bit got;
    tbl[0] = '{1'b0, 8'd127, 28'h4000004, 1'b0, 1'b0, 32'h3F800000, 1'b0, 1'b0};
    tbl[1] = '{1'b0, 8'd127, 28'h400000C, 1'b0, 1'b0, 32'h3F800002, 1'b0, 1'b0};
    tbl[2] = '{1'b0, 8'd127, 28'h4000006, 1'b0, 1'b0, 32'h3F800001, 1'b0, 1'b0};
    tbl[3] = '{1'b0, 8'd127, 28'h7FFFFFC, 1'b0, 1'b0, 32'h40000000, 1'b0, 1'b0};
    tbl[4] = '{1'b0, 8'd127, 28'h8000009, 1'b0, 1'b0, 32'h40000001, 1'b0, 1'b0};
    tbl[5] = '{1'b0, 8'd130, 28'h0800000, 1'b0, 1'b0, 32'h3F800000, 1'b0, 1'b0};
    for (int t = 0; t < 6; t++) begin
      send_and_get(tbl[t], zz, ov, un, lat, got);
      checks++;
      if (!got || {zz, ov, un} !== {tbl[t].z, tbl[t].ov, tbl[t].un}) begin
        errors++;
        $display("FAIL round[%0d]: got %h/%b%b (valid %b) want %h/%b%b", t, zz, ov, un, got, tbl[t].z, tbl[t].ov, tbl[t].un);
      end
    end
  endtask

  task automatic test_special;
    vec_t tbl[7];
    logic [31:0] zz; logic ov, un; int lat; bit got;
    tbl[0] = '{1'b0, 8'd254, 28'h8000000, 1'b0, 1'b0, 32'h7F800000, 1'b1, 1'b0};
    tbl[1] = '{1'b1, 8'd254, 28'h7FFFFFC, 1'b0, 1'b0, 32'hFF800000, 1'b1, 1'b0};
    tbl[2] = '{1'b0, 8'd254, 28'h4000000, 1'b0, 1'b0, 32'h7F000000, 1'b0, 1'b0};
    tbl[3] = '{1'b1, 8'd5,   28'h0123456, 1'b1, 1'b0, QNAN,         1'b0, 1'b0};
    tbl[4] = '{1'b0, 8'd0,   28'h0000000, 1'b1, 1'b1, QNAN,         1'b0, 1'b0};
    tbl[5] = '{1'b1, 8'd3,   28'h4000000, 1'b0, 1'b1, 32'hFF800000, 1'b0, 1'b0};
    tbl[6] = '{1'b0, 8'd0,   28'h0000000, 1'b0, 1'b1, 32'h7F800000, 1'b0, 1'b0};
    for (int t = 0; t < 7; t++) begin
      send_and_get(tbl[t], zz, ov, un, lat, got);
      checks++;
      if (!got || {zz, ov, un} !== {tbl[t].z, tbl[t].ov, tbl[t].un}) begin
        errors++;
        $display("FAIL special[%0d]: got %h/%b%b (valid %b) want %h/%b%b", t, zz, ov, un, got, tbl[t].z, tbl[t].ov, tbl[t].un);
      end
    end
  endtask

  task automatic test_back_to_back;
    vec_t tbl[4];
    int idx, nout;
    bit hs_in, hs_out;
    logic [31:0] held;
    tbl[0] = '{1'b0, 8'd127, 28'h4000000, 1'b0, 1'b0, 32'h3F800000, 1'b0, 1'b0};
    tbl[1] = '{1'b0, 8'd128, 28'h4000000, 1'b0, 1'b0, 32'h40000000, 1'b0, 1'b0};
    tbl[2] = '{1'b0, 8'd128, 28'h6000000, 1'b0, 1'b0, 32'h40400000, 1'b0, 1'b0};
    tbl[3] = '{1'b1, 8'd127, 28'h6000000, 1'b0, 1'b0, 32'hBFC00000, 1'b0, 1'b0};
    idx = 0; nout = 0; held = '0;
    out_ready = 1'b0;
    load(tbl[0]);
    in_valid = 1'b1;
    for (int cyc = 0; cyc < 30 && nout < 4; cyc++) begin
      if (cyc == 4) out_ready = 1'b1;
      #1;
      if (cyc == 2) begin
        checks++; if (in_ready !== 1'b0 || idx != 2) begin errors++; $display("FAIL b2b_stall: in_ready %b accepts %0d want 0 and 2", in_ready, idx); end
        checks++; if (out_valid !== 1'b1 || z !== tbl[0].z) begin errors++; $display("FAIL b2b_first_out: valid %b z %h want 1 %h", out_valid, z, tbl[0].z); end
        held = z;
      end
      if (cyc == 3 || cyc == 4) begin
        checks++; if (out_valid !== 1'b1 || z !== held) begin errors++; $display("FAIL b2b_hold[%0d]: valid %b z %h want 1 %h", cyc, out_valid, z, held); end
      end
      hs_in  = in_valid && in_ready;
      hs_out = out_valid && out_ready;
      if (hs_out) begin
        checks++;
        if (z !== tbl[nout].z) begin errors++; $display("FAIL b2b_order[%0d]: got %h want %h", nout, z, tbl[nout].z); end
        nout++;
      end
      @(posedge clk); #1;
      if (hs_in) begin
        idx++;
        if (idx < 4) load(tbl[idx]);
        else in_valid = 1'b0;
      end
    end
    in_valid = 1'b0;
    checks++; if (nout != 4) begin errors++; $display("FAIL b2b_count: got %0d outputs want 4", nout); end
    hs_out = 1'b0;
    repeat (3) begin
      #1; if (out_valid) hs_out = 1'b1;
      @(posedge clk); #1;
    end
    checks++; if (hs_out) begin errors++; $display("FAIL b2b_extra: got extra output want none"); end
  endtask

  task automatic test_reset_flush;
    vec_t v;
    bit stale;
    v = '{1'b0, 8'd127, 28'h4000000, 1'b0, 1'b0, 32'h3F800000, 1'b0, 1'b0};
    out_ready = 1'b1;
    load(v);
    in_valid = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_out_valid: got %b want 0", out_valid); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL flush_in_ready: got %b want 1", in_ready); end
    stale = 1'b0;
    repeat (6) begin
      @(posedge clk); #1;
      if (out_valid) stale = 1'b1;
    end
    checks++; if (stale) begin errors++; $display("FAIL flush_stale: got stale output want none"); end
  endtask

  initial begin
    test_reset();
    test_latency();
    test_zero_underflow();
    test_rounding();
    test_special();
    test_back_to_back();
    test_reset_flush();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
